// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns the IF program counter and fetches over a
// variable-latency instruction-memory port with a single outstanding request.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      next_pc,
  input  logic             redirect,
  input  logic             stall,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      IF_pc,
  output logic [31:0]      IF_instr,
  output logic             IF_valid,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q;
  logic [31:0]       instr_q;
  logic [CNT_W-1:0]  bubble_q;
  logic              load_pc;
  logic              capture;
  logic [31:0]       aligned_pc;

  assign aligned_pc = next_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_d = state_q;
    load_pc = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        load_pc = redirect;
        // An accepted request whose address was just redirected must be drained.
        if (imem_gnt) state_d = redirect ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        load_pc = redirect;
        if (imem_rvalid) begin
          state_d = redirect ? ST_REQ : ST_HOLD;
          capture = !redirect;
        end else if (redirect) begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (redirect || !stall) begin
          load_pc = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        load_pc = redirect;
        if (imem_rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      bubble_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_pc) pc_q <= aligned_pc;
      if (capture) instr_q <= imem_rdata;
      if (state_q != ST_BOOT && state_q != ST_HOLD && bubble_q != {CNT_W{1'b1}})
        bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign imem_req     = (state_q == ST_REQ);
  assign imem_addr    = pc_q;
  assign IF_pc        = pc_q;
  assign IF_valid     = (state_q == ST_HOLD);
  assign IF_instr     = (state_q == ST_HOLD) ? instr_q : NOP_INSTR;
  assign bubble_count = bubble_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the fetch pipeline.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk, rst;
  logic [31:0] next_pc, imem_rdata;
  logic        redirect, stall, imem_gnt, imem_rvalid;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_instr;
  logic [15:0] bubble_count;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;
  logic [2:0]  s_bubble;

  int checks = 0;
  int fails  = 0;

  // Model: boot cycle, outstanding request, stale flag, held instruction.
  bit          m_boot, m_pending, m_stale, m_have;
  logic [31:0] m_pc, m_instr;
  int          m_bub;

  fetch_sequencer #(.RESET_PC(RST_PC), .NOP_INSTR(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .redirect(redirect), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .IF_pc(if_pc),
    .IF_instr(if_instr), .IF_valid(if_valid), .bubble_count(bubble_count)
  );

  fetch_sequencer #(.RESET_PC(RST_PC), .NOP_INSTR(NOP), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .next_pc(next_pc), .redirect(redirect), .stall(stall),
    .imem_req(s_req), .imem_addr(s_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .IF_pc(s_pc),
    .IF_instr(s_instr), .IF_valid(s_valid), .bubble_count(s_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_reset();
    m_boot = 1; m_pending = 0; m_stale = 0; m_have = 0;
    m_pc = RST_PC; m_instr = NOP; m_bub = 0;
  endtask

  task automatic model_step();
    if (!m_boot && !m_have) m_bub++;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_have) begin
      if (redirect || !stall) begin m_pc = next_pc & ~32'h3; m_have = 0; end
    end else if (!m_pending) begin
      if (redirect) m_pc = next_pc & ~32'h3;
      if (imem_gnt) begin m_pending = 1; m_stale = redirect; end
    end else if (imem_rvalid) begin
      if (redirect) m_pc = next_pc & ~32'h3;
      else if (!m_stale) begin m_have = 1; m_instr = imem_rdata; end
      m_pending = 0; m_stale = 0;
    end else if (redirect) begin
      m_pc = next_pc & ~32'h3; m_stale = 1;
    end
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic re, input logic st, input logic [31:0] np);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    redirect = re; stall = st; next_pc = np;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (if_pc !== RST_PC) begin fails++; $display("[TB] FAIL reset_pc: got %h expected %h", if_pc, RST_PC); end
    checks++; if (if_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", if_valid); end
    checks++; if (if_instr !== NOP) begin fails++; $display("[TB] FAIL reset_instr: got %h expected %h", if_instr, NOP); end
    checks++; if (bubble_count !== 16'd0) begin fails++; $display("[TB] FAIL reset_bubble: got %0d expected 0", bubble_count); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_fetch();
    drive(1, 0, 32'h0, 0, 0, 32'h104);
    checks++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL boot_req: got %b expected 0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("[TB] FAIL first_req: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
    step();
    drive(0, 1, 32'h0050_0093, 0, 0, 32'h104);
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin fails++; $display("[TB] FAIL wait_outputs: got req=%b valid=%b expected 0/0", imem_req, if_valid); end
    step();
    drive(0, 0, 32'h0, 0, 0, 32'h104);
    checks++; if (if_valid !== 1'b1 || if_instr !== 32'h0050_0093 || if_pc !== 32'h100) begin fails++; $display("[TB] FAIL hold_first: got valid=%b instr=%h pc=%h expected 1/00500093/00000100", if_valid, if_instr, if_pc); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin fails++; $display("[TB] FAIL second_req: got req=%b addr=%h expected 1/00000104", imem_req, imem_addr); end
    checks++; if (bubble_count !== 16'd2) begin fails++; $display("[TB] FAIL bubble_basic: got %0d expected 2", bubble_count); end
  endtask

  task automatic test_stall();
    drive(1, 0, 32'h0, 0, 0, 32'h108);
    step();
    drive(0, 1, 32'h00A0_0113, 0, 0, 32'h108);
    step();
    drive(0, 0, 32'h0, 0, 1, 32'h108);
    for (int i = 0; i < 4; i++) begin
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h104 || if_instr !== 32'h00A0_0113 || imem_req !== 1'b0) begin fails++; $display("[TB] FAIL stall_hold[%0d]: got valid=%b pc=%h instr=%h req=%b", i, if_valid, if_pc, if_instr, imem_req); end
      step();
    end
    stall = 1'b0;
    checks++; if (if_valid !== 1'b1) begin fails++; $display("[TB] FAIL stall_last: got valid=%b expected 1", if_valid); end
    step();
    checks++; if (imem_req !== 1'b1 || if_pc !== 32'h108 || if_valid !== 1'b0) begin fails++; $display("[TB] FAIL stall_release: got req=%b pc=%h valid=%b expected 1/00000108/0", imem_req, if_pc, if_valid); end
  endtask

  task automatic test_redirect_wait();
    drive(1, 0, 32'h0, 0, 0, 32'h10C);
    step();
    drive(0, 0, 32'h0, 1, 0, 32'h200);
    step();
    drive(0, 0, 32'h0, 0, 0, 32'h204);
    for (int i = 0; i < 2; i++) begin
      checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h200) begin fails++; $display("[TB] FAIL drain[%0d]: got req=%b valid=%b addr=%h expected 0/0/00000200", i, imem_req, if_valid, imem_addr); end
      step();
    end
    drive(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h204);
    checks++; if (if_valid !== 1'b0) begin fails++; $display("[TB] FAIL drain_rvalid: got valid=%b expected 0", if_valid); end
    step();
    drive(0, 0, 32'h0, 0, 0, 32'h204);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || if_valid !== 1'b0 || if_instr !== NOP) begin fails++; $display("[TB] FAIL after_drain: got req=%b addr=%h valid=%b instr=%h", imem_req, imem_addr, if_valid, if_instr); end
  endtask

  task automatic test_redirect_same_cycle();
    drive(1, 0, 32'h0, 0, 0, 32'h204);
    step();
    drive(0, 1, 32'h1234_5678, 1, 0, 32'h300);
    step();
    drive(1, 0, 32'h0, 0, 0, 32'h304);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || if_valid !== 1'b0) begin fails++; $display("[TB] FAIL redirect_rvalid: got req=%b addr=%h valid=%b expected 1/00000300/0", imem_req, imem_addr, if_valid); end
    step();
    drive(0, 1, 32'h0010_0073, 0, 0, 32'h304);
    step();
    drive(0, 0, 32'h0, 1, 1, 32'h0000_0403);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h300 || if_instr !== 32'h0010_0073) begin fails++; $display("[TB] FAIL hold_300: got valid=%b pc=%h instr=%h", if_valid, if_pc, if_instr); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400 || if_valid !== 1'b0) begin fails++; $display("[TB] FAIL redirect_over_stall: got req=%b addr=%h valid=%b expected 1/00000400/0", imem_req, imem_addr, if_valid); end
  endtask

  task automatic test_gnt_low();
    int start;
    drive(0, 0, 32'h0, 0, 0, 32'h404);
    start = m_bub;
    for (int i = 0; i < 5; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin fails++; $display("[TB] FAIL gnt_low[%0d]: got req=%b addr=%h expected 1/00000400", i, imem_req, imem_addr); end
      step();
    end
    checks++; if (bubble_count !== 16'(start + 5)) begin fails++; $display("[TB] FAIL bubble_gnt_low: got %0d expected %0d", bubble_count, start + 5); end
    checks++; if (s_bubble !== 3'(sat(m_bub, 7))) begin fails++; $display("[TB] FAIL bubble_saturate: got %0d expected %0d", s_bubble, sat(m_bub, 7)); end
  endtask

  task automatic test_reset_midop();
    drive(1, 0, 32'h0, 0, 0, 32'h404);
    step();
    drive(0, 0, 32'h0, 0, 0, 32'h404);
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h400) begin fails++; $display("[TB] FAIL pre_reset_wait: got req=%b addr=%h expected 0/00000400", imem_req, imem_addr); end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++; if (imem_req !== 1'b0 || if_pc !== RST_PC || if_valid !== 1'b0 || if_instr !== NOP || bubble_count !== 16'd0 || s_bubble !== 3'd0) begin fails++; $display("[TB] FAIL midop_reset: got req=%b pc=%h valid=%b instr=%h bub=%0d sbub=%0d", imem_req, if_pc, if_valid, if_instr, bubble_count, s_bubble); end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 32'hBADC_0DE5, 0, 0, 32'h500);
    checks++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL boot_after_reset: got req=%b expected 0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC || if_valid !== 1'b0) begin fails++; $display("[TB] FAIL first_req_after_reset: got req=%b addr=%h valid=%b", imem_req, imem_addr, if_valid); end
    step();
    checks++; if (imem_req !== 1'b1 || if_valid !== 1'b0 || if_instr !== NOP) begin fails++; $display("[TB] FAIL late_rvalid_ignored: got req=%b valid=%b instr=%h", imem_req, if_valid, if_instr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
            ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), $urandom());
      checks++; if (imem_req !== (!m_boot && !m_pending && !m_have)) begin fails++; $display("[TB] FAIL rnd_req[%0d]: got %b expected %b", i, imem_req, !m_boot && !m_pending && !m_have); end
      checks++; if (imem_addr !== m_pc || if_pc !== m_pc) begin fails++; $display("[TB] FAIL rnd_pc[%0d]: got addr=%h pc=%h expected %h", i, imem_addr, if_pc, m_pc); end
      checks++; if (if_valid !== m_have) begin fails++; $display("[TB] FAIL rnd_valid[%0d]: got %b expected %b", i, if_valid, m_have); end
      checks++; if (if_instr !== (m_have ? m_instr : NOP)) begin fails++; $display("[TB] FAIL rnd_instr[%0d]: got %h expected %h", i, if_instr, m_have ? m_instr : NOP); end
      checks++; if (bubble_count !== 16'(sat(m_bub, 65535))) begin fails++; $display("[TB] FAIL rnd_bubble[%0d]: got %0d expected %0d", i, bubble_count, sat(m_bub, 65535)); end
      checks++; if (s_bubble !== 3'(sat(m_bub, 7))) begin fails++; $display("[TB] FAIL rnd_sat_bubble[%0d]: got %0d expected %0d", i, s_bubble, sat(m_bub, 7)); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_gnt_low();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
